// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RATE  = 2'd2
  } rep_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, stability-counter debouncer and
// optional auto-repeat generator producing registered press/release pulses.
module button_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES    = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int DB_W  = cnt_width(DB_CYCLES);
  localparam int REP_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic             s1;
  logic             s2;
  logic             level;
  logic [DB_W-1:0]  db_cnt;
  logic             accept;
  logic             rise;
  logic             fall;

  rep_state_t       state;
  rep_state_t       state_nxt;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_cnt_nxt;
  logic             rep_fire;

  // s2 has disagreed with level for DB_CYCLES consecutive edges.
  assign accept = (s2 != level) && (db_cnt == DB_LAST);
  assign rise   = accept && s2;
  assign fall   = accept && !s2;

  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // blocking here would collapse s1->s2 into a single stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
      if (s2 == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        level  <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // NOTE: defaults first so every path assigns every output; otherwise
  // the unassigned branches infer latches.
  always_comb begin
    state_nxt   = state;
    rep_cnt_nxt = rep_cnt;
    rep_fire    = 1'b0;
    if (!en_i || fall) begin
      state_nxt   = IDLE;
      rep_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise && REPEAT_EN) begin
            state_nxt   = DELAY;
            rep_cnt_nxt = '0;
          end
        end
        DELAY: begin
          if (rep_cnt == DELAY_LAST) begin
            rep_fire    = 1'b1;
            rep_cnt_nxt = '0;
            state_nxt   = RATE;
          end else begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
          end
        end
        RATE: begin
          if (rep_cnt == RATE_LAST) begin
            rep_fire    = 1'b1;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt + REP_W'(1);
          end
        end
        default: begin
          state_nxt   = IDLE;
          rep_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rep_cnt   <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      rep_cnt   <= rep_cnt_nxt;
      press_o   <= en_i && (rise || rep_fire);
      release_o <= en_i && fall;
    end
  end

  assign level_o = level;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: per-channel debounced levels,
// press/release/repeat pulses, and a registered enable acknowledge.
module button_conditioner
  import button_pkg::*;
#(
  parameter int              N_CH         = 3,
  parameter int              DB_CYCLES    = 4,
  parameter int              REPEAT_DELAY = 16,
  parameter int              REPEAT_RATE  = 4,
  parameter logic [N_CH-1:0] REPEAT_MASK  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic            valid_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
    end else begin
      valid_o <= en_i;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) u_channel (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i),
      .btn_i    (btn_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i])
    );
  end

endmodule
